// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: shared FSM states, segment codes and BCD helpers for bcd_display.
package bcd_display_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W = 4 * NUM_DIGITS;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/bcd_display_if.sv
// bcd_display_if: binary value in, busy flag and multiplexed 7-segment lines out.
interface bcd_display_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] indata;
    logic              busy;
    logic [6:0]        seg;
    logic [3:0]        an;
    modport master(output indata, input busy, seg, an);
    modport slave(input indata, output busy, seg, an);
endinterface

// File: rtl/bcd_display_seg7_decode.sv
// seg7_decode: BCD digit to active-low {g,f,e,d,c,b,a}; codes 10..15 are blank.
module seg7_decode
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_display.sv
// bcd_display: serial binary-to-BCD conversion plus 4-digit multiplexed display scan.
// Define BCD_DISPLAY_LZ_BLANK_EN to blank leading zeros (units digit always shown).
module bcd_display
    import bcd_display_pkg::*;
#(
    parameter int SCAN_CYCLES = 50000,
    parameter int DATA_W = 10
) (
    input logic clk,
    input logic rst,
    bcd_display_if.slave bus
);
    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d, last_q, last_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, digits_q, digits_d, adj;
    logic [3:0]        bit_q, bit_d;
    logic              valid_q, valid_d, busy_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [6:0]        seg_q, seg_d, dec_seg;
    logic [3:0]        an_q, an_d, dec_in;
    logic              lz, wrap;

    always_comb begin
        state_d = state_q;
        bin_d = bin_q;
        last_d = last_q;
        bcd_d = bcd_q;
        digits_d = digits_q;
        bit_d = bit_q;
        valid_d = valid_q;
        adj = add3(bcd_q);
        case (state_q)
            IDLE: if (!valid_q || bus.indata != last_q) begin
                bin_d = bus.indata;
                last_d = bus.indata;
                bcd_d = '0;
                bit_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                bit_d = bit_q + 4'd1;
                state_d = (bit_q == 4'(DATA_W - 1)) ? DONE : SHIFT;
            end
            DONE: begin
                digits_d = bcd_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BCD_DISPLAY_LZ_BLANK_EN
    assign lz = (idx_q != 2'd0) && ((digits_q >> {idx_q, 2'b00}) == '0);
`else
    assign lz = 1'b0;
`endif

    always_comb begin
        wrap = (cnt_q == CW'(SCAN_CYCLES - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        dec_in = digits_q[{idx_q, 2'b00} +: 4];
        seg_d = (!valid_q || lz) ? SEG_BLANK : dec_seg;
        an_d = ~(4'b0001 << idx_q);
    end

    seg7_decode u_dec (
        .bcd(dec_in),
        .seg(dec_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            bin_q <= '0;
            last_q <= '0;
            bcd_q <= '0;
            digits_q <= '0;
            bit_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q <= 4'hF;
        end else begin
            state_q <= state_d;
            bin_q <= bin_d;
            last_q <= last_d;
            bcd_q <= bcd_d;
            digits_q <= digits_d;
            bit_q <= bit_d;
            valid_q <= valid_d;
            busy_q <= (state_d != IDLE);
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q <= an_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.seg = seg_q;
    assign bus.an = an_q;
endmodule

// File: tb/tb_bcd_display.sv
// tb_bcd_display: directed vectors plus a cycle-level reference model of the display.
module tb_bcd_display;
    localparam int SCAN = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b1;
    int tests = 0;
    int fails = 0;
    int nb;

    bcd_display_if #(.DATA_W(10)) bus ();

    bcd_display #(.SCAN_CYCLES(SCAN), .DATA_W(10)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input logic v, input int val, input int idx);
        int p = 1;
        for (int i = 0; i < idx; i++) p *= 10;
        if (!v) return 7'h7F;
`ifdef BCD_DISPLAY_LZ_BLANK_EN
        if (idx != 0 && val < p) return 7'h7F;
`endif
        return pat((val / p) % 10);
    endfunction

    // Reference: a conversion takes 11 cycles from start, then the value is shown.
    int m_timer, m_val, m_last, m_cnt, m_idx;
    logic m_valid, e_busy;
    logic [6:0] e_seg;
    logic [3:0] e_an;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_timer <= 0; m_val <= 0; m_last <= 0; m_cnt <= 0; m_idx <= 0;
            m_valid <= 1'b0; e_busy <= 1'b0; e_seg <= 7'h7F; e_an <= 4'hF;
        end else begin
            e_an <= ~(4'b0001 << m_idx);
            e_seg <= model_seg(m_valid, m_val, m_idx);
            m_cnt <= (m_cnt == SCAN - 1) ? 0 : m_cnt + 1;
            if (m_cnt == SCAN - 1) m_idx <= (m_idx + 1) % 4;
            if (m_timer == 0) begin
                if (!m_valid || int'(bus.indata) != m_last) begin
                    m_last <= int'(bus.indata);
                    m_timer <= 11;
                    e_busy <= 1'b1;
                end else e_busy <= 1'b0;
            end else begin
                m_timer <= m_timer - 1;
                e_busy <= (m_timer != 1);
                if (m_timer == 1) begin
                    m_val <= m_last;
                    m_valid <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("model_an", 32'(bus.an), 32'(e_an));
            check("model_seg", 32'(bus.seg), 32'(e_seg));
            check("model_busy", 32'(bus.busy), 32'(e_busy));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int i;
        tick(1);
        for (i = 0; i < 40 && bus.busy; i++) tick(1);
        if (bus.busy) check("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (bus.busy) n++;
        end
    endtask

    task automatic show(input string name, input logic [3:0] an_v, input logic [6:0] seg_v);
        int i;
        for (i = 0; i < 20 && bus.an !== an_v; i++) tick(1);
        check({name, "_an"}, 32'(bus.an), 32'(an_v));
        check(name, 32'(bus.seg), 32'(seg_v));
    endtask

`ifdef BCD_DISPLAY_LZ_BLANK_EN
    localparam logic [6:0] LZ0 = 7'h7F;
`else
    localparam logic [6:0] LZ0 = 7'h40;
`endif

    initial begin
        bus.indata = 10'd0;
        tick(3);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        count_busy(nb);
        check("busy_len_0", 32'(nb), 32'd11);
        show("z_u", 4'hE, 7'h40);
        show("z_t", 4'hD, LZ0);
        show("z_h", 4'hB, LZ0);
        show("z_k", 4'h7, LZ0);

        bus.indata = 10'd6;
        count_busy(nb);
        check("busy_len_6", 32'(nb), 32'd11);
        show("six_u", 4'hE, 7'h02);
        show("six_t", 4'hD, LZ0);

        bus.indata = 10'd1023;
        wait_idle();
        tick(2);
        show("max_u", 4'hE, 7'h30);
        show("max_t", 4'hD, 7'h24);
        show("max_h", 4'hB, 7'h40);
        show("max_k", 4'h7, 7'h79);

        bus.indata = 10'd21;
        tick(3);
        check("mid_busy", 32'(bus.busy), 32'd1);
        bus.indata = 10'd52;
        wait_idle();
        tick(1);
        check("reconv_busy", 32'(bus.busy), 32'd1);
        wait_idle();
        tick(2);
        show("f52_u", 4'hE, 7'h24);
        show("f52_t", 4'hD, 7'h12);
        show("f52_h", 4'hB, LZ0);

        bus.indata = 10'd700;
        tick(4);
        #2 rst = 1'b0;
        #1;
        check("arst_seg", 32'(bus.seg), 32'h7F);
        check("arst_an", 32'(bus.an), 32'hF);
        check("arst_busy", 32'(bus.busy), 32'd0);
        bus.indata = 10'd52;
        tick(2);
        rst = 1'b1;
        wait_idle();
        tick(2);
        show("r52_u", 4'hE, 7'h24);
        show("r52_t", 4'hD, 7'h12);

        chk_en = 1'b0;
        force dut.u_dec.bcd = 4'd10; #1 check("dec10", 32'(dut.u_dec.seg), 32'h7F);
        force dut.u_dec.bcd = 4'd11; #1 check("dec11", 32'(dut.u_dec.seg), 32'h7F);
        force dut.u_dec.bcd = 4'd12; #1 check("dec12", 32'(dut.u_dec.seg), 32'h7F);
        force dut.u_dec.bcd = 4'd13; #1 check("dec13", 32'(dut.u_dec.seg), 32'h7F);
        force dut.u_dec.bcd = 4'd14; #1 check("dec14", 32'(dut.u_dec.seg), 32'h7F);
        force dut.u_dec.bcd = 4'd15; #1 check("dec15", 32'(dut.u_dec.seg), 32'h7F);
        release dut.u_dec.bcd;
        tick(3);
        chk_en = 1'b1;
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required finish before 200000");
        $fatal(1);
    end
endmodule
